// File: rtl/roce_stack_mm2s_engine.sv
// RoCE datamover MM2S responder: 104-bit command -> 4 KB-safe AXI4 read bursts -> AXIS data + 8-bit status.
// Optional build macro ROCE_MM2S_PERF_CNT_EN adds cmd_done_cnt_o / beat_cnt_o performance counters.
module roce_stack_mm2s_engine #(
   parameter int AXI4_DATA_WIDTH = 512,
   parameter int MAX_BURST_BEATS = 64
) (
   input  logic                         axis_aclk_i,
   input  logic                         aresetn_i,
   input  logic                         s_axis_cmd_tvalid_i,
   output logic                         s_axis_cmd_tready_o,
   input  logic [103:0]                 s_axis_cmd_tdata_i,
   output logic                         m_axi_arid_o,
   output logic [63:0]                  m_axi_araddr_o,
   output logic [7:0]                   m_axi_arlen_o,
   output logic [2:0]                   m_axi_arsize_o,
   output logic [1:0]                   m_axi_arburst_o,
   output logic [3:0]                   m_axi_arcache_o,
   output logic [2:0]                   m_axi_arprot_o,
   output logic                         m_axi_arvalid_o,
   input  logic                         m_axi_arready_i,
   input  logic [AXI4_DATA_WIDTH-1:0]   m_axi_rdata_i,
   input  logic [1:0]                   m_axi_rresp_i,
   input  logic                         m_axi_rlast_i,
   input  logic                         m_axi_rvalid_i,
   output logic                         m_axi_rready_o,
   output logic [AXI4_DATA_WIDTH-1:0]   m_axis_tdata_o,
   output logic [AXI4_DATA_WIDTH/8-1:0] m_axis_tkeep_o,
   output logic                         m_axis_tlast_o,
   output logic                         m_axis_tvalid_o,
   input  logic                         m_axis_tready_i,
   output logic [7:0]                   m_axis_sts_tdata_o,
   output logic                         m_axis_sts_tvalid_o,
   input  logic                         m_axis_sts_tready_i,
`ifdef ROCE_MM2S_PERF_CNT_EN
   output logic [31:0]                  cmd_done_cnt_o,
   output logic [31:0]                  beat_cnt_o,
`endif
   output logic                         err_o
);

   localparam int BYTES   = AXI4_DATA_WIDTH / 8;
   localparam int LOG2B   = $clog2(BYTES);
   localparam int BEAT_W  = 24 - LOG2B;
   localparam int BURST_W = 9;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CHECK  = 3'd1,
      ST_ADDR   = 3'd2,
      ST_DATA   = 3'd3,
      ST_STATUS = 3'd4
   } state_t;

   state_t               state_r, state_nxt_s;
   logic                 cmd_tready_r;
   logic [22:0]          btt_r;
   logic [63:0]          addr_r;
   logic [3:0]           tag_r;
   logic                 eof_r, type_r;
   logic [BEAT_W-1:0]    beats_left_r;
   logic [BURST_W-1:0]   burst_r, beat_idx_r, burst_s, cap_s;
   logic [12:0]          page_beats_s;
   logic [23:0]          btt_round_s;
   logic                 slverr_r, decerr_r, interr_r, any_err_s;
   logic                 cmd_hs_s, ar_hs_s, beat_hs_s, sts_hs_s;
   logic                 last_of_burst_s, burst_end_s, cmd_end_s, final_beat_s, bad_cmd_s;
   logic                 unused_cmd_bits_s;

   // Byte enables of the last beat: only the BTT remainder bytes are valid.
   function automatic logic [BYTES-1:0] tail_keep(input logic [LOG2B-1:0] rem);
      return (rem == {LOG2B{1'b0}}) ? {BYTES{1'b1}} : ~({BYTES{1'b1}} << rem);
   endfunction

   assign unused_cmd_bits_s = ^{s_axis_cmd_tdata_i[103:100], s_axis_cmd_tdata_i[31],
                                s_axis_cmd_tdata_i[29:24]};

   assign cmd_hs_s     = (state_r == ST_IDLE) && cmd_tready_r && s_axis_cmd_tvalid_i;
   assign ar_hs_s      = (state_r == ST_ADDR) && m_axi_arready_i;
   assign beat_hs_s    = (state_r == ST_DATA) && m_axi_rvalid_i && m_axis_tready_i;
   assign sts_hs_s     = (state_r == ST_STATUS) && m_axis_sts_tready_i;
   assign btt_round_s  = {1'b0, s_axis_cmd_tdata_i[22:0]} + 24'(BYTES - 1);

   // Burst size is the smallest of remaining beats, the burst cap and the room left in the 4 KB page.
   assign page_beats_s = 13'((13'h1000 - {1'b0, addr_r[11:0]}) >> LOG2B);
   assign cap_s        = (32'(page_beats_s) < 32'(MAX_BURST_BEATS)) ? BURST_W'(page_beats_s)
                                                                     : BURST_W'(MAX_BURST_BEATS);
   assign burst_s      = (32'(beats_left_r) < 32'(cap_s)) ? BURST_W'(beats_left_r) : cap_s;

   assign last_of_burst_s = (beat_idx_r == (burst_r - 9'd1));
   assign burst_end_s     = beat_hs_s && (m_axi_rlast_i || last_of_burst_s);
   assign cmd_end_s       = (beats_left_r == BEAT_W'(burst_r));
   assign final_beat_s    = last_of_burst_s && cmd_end_s;
   assign bad_cmd_s       = (btt_r == 23'd0) || (addr_r[LOG2B-1:0] != {LOG2B{1'b0}}) || !type_r;
   assign any_err_s       = slverr_r | decerr_r | interr_r;

   // State register.
   always_ff @(posedge axis_aclk_i) begin
      if (!aresetn_i) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE:   state_nxt_s = cmd_hs_s ? ST_CHECK : ST_IDLE;
         ST_CHECK:  state_nxt_s = bad_cmd_s ? ST_STATUS : ST_ADDR;
         ST_ADDR:   state_nxt_s = ar_hs_s ? ST_DATA : ST_ADDR;
         ST_DATA: begin
            if (burst_end_s) begin
               state_nxt_s = cmd_end_s ? ST_STATUS : ST_ADDR;
            end else begin
               state_nxt_s = ST_DATA;
            end
         end
         ST_STATUS: state_nxt_s = sts_hs_s ? ST_IDLE : ST_STATUS;
         default:   state_nxt_s = ST_IDLE;
      endcase
   end

   // Command latch, burst bookkeeping and sticky error flags.
   always_ff @(posedge axis_aclk_i) begin
      if (!aresetn_i) begin
         cmd_tready_r <= 1'b0;
         btt_r        <= 23'd0;
         addr_r       <= 64'd0;
         tag_r        <= 4'd0;
         eof_r        <= 1'b0;
         type_r       <= 1'b0;
         beats_left_r <= {BEAT_W{1'b0}};
         burst_r      <= {BURST_W{1'b0}};
         beat_idx_r   <= {BURST_W{1'b0}};
         slverr_r     <= 1'b0;
         decerr_r     <= 1'b0;
         interr_r     <= 1'b0;
      end else begin
         cmd_tready_r <= (state_nxt_s == ST_IDLE);
         if (cmd_hs_s) begin
            btt_r        <= s_axis_cmd_tdata_i[22:0];
            type_r       <= s_axis_cmd_tdata_i[23];
            eof_r        <= s_axis_cmd_tdata_i[30];
            addr_r       <= s_axis_cmd_tdata_i[95:32];
            tag_r        <= s_axis_cmd_tdata_i[99:96];
            beats_left_r <= BEAT_W'(btt_round_s >> LOG2B);
            slverr_r     <= 1'b0;
            decerr_r     <= 1'b0;
            interr_r     <= 1'b0;
         end
         if ((state_r == ST_CHECK) && bad_cmd_s) begin
            interr_r <= 1'b1;
         end
         if (ar_hs_s) begin
            burst_r    <= burst_s;
            beat_idx_r <= {BURST_W{1'b0}};
         end
         if (beat_hs_s) begin
            if (m_axi_rresp_i == 2'b10) slverr_r <= 1'b1;
            if (m_axi_rresp_i == 2'b11) decerr_r <= 1'b1;
            // A burst closes on rlast or on its expected last beat; disagreement is a protocol error.
            if (burst_end_s) begin
               addr_r       <= addr_r + (64'(burst_r) << LOG2B);
               beats_left_r <= beats_left_r - BEAT_W'(burst_r);
               if (m_axi_rlast_i != last_of_burst_s) interr_r <= 1'b1;
            end else begin
               beat_idx_r <= beat_idx_r + 9'd1;
            end
         end
      end
   end

`ifdef ROCE_MM2S_PERF_CNT_EN
   // Free-running performance counters, wrapping at 2^32.
   always_ff @(posedge axis_aclk_i) begin
      if (!aresetn_i) begin
         cmd_done_cnt_o <= 32'd0;
         beat_cnt_o     <= 32'd0;
      end else begin
         if (sts_hs_s)  cmd_done_cnt_o <= cmd_done_cnt_o + 32'd1;
         if (beat_hs_s) beat_cnt_o     <= beat_cnt_o + 32'd1;
      end
   end
`endif

   assign s_axis_cmd_tready_o = cmd_tready_r;

   assign m_axi_arid_o    = 1'b0;
   assign m_axi_arsize_o  = 3'(LOG2B);
   assign m_axi_arburst_o = 2'b01;
   assign m_axi_arcache_o = 4'b0011;
   assign m_axi_arprot_o  = 3'b000;
   assign m_axi_arvalid_o = (state_r == ST_ADDR);
   assign m_axi_araddr_o  = (state_r == ST_ADDR) ? addr_r : 64'd0;
   assign m_axi_arlen_o   = (state_r == ST_ADDR) ? 8'(burst_s - 9'd1) : 8'd0;

   assign m_axi_rready_o  = (state_r == ST_DATA) && m_axis_tready_i;
   assign m_axis_tvalid_o = (state_r == ST_DATA) && m_axi_rvalid_i;
   assign m_axis_tdata_o  = (state_r == ST_DATA) ? m_axi_rdata_i : {AXI4_DATA_WIDTH{1'b0}};
   assign m_axis_tkeep_o  = (state_r != ST_DATA) ? {BYTES{1'b0}} :
                            final_beat_s ? tail_keep(btt_r[LOG2B-1:0]) : {BYTES{1'b1}};
   assign m_axis_tlast_o  = (state_r == ST_DATA) && eof_r && final_beat_s;

   assign m_axis_sts_tvalid_o = (state_r == ST_STATUS);
   assign m_axis_sts_tdata_o  = {~any_err_s, slverr_r, decerr_r, interr_r, tag_r};
   assign err_o               = sts_hs_s && any_err_s;

endmodule
